// File: rtl/rs_gf_pkg.sv
// GF(2^8) helpers shared by the Reed-Solomon syndrome stream.
//   SYM_W        symbol width in bits
//   sym_t        one field element / symbol
//   gf_poly_t    field generator polynomial including the x^8 term
//   gf_mul       general GF(2^8) multiply reduced by a given polynomial
//   gf_pow_const alpha^e, intended for elaboration-time constants
package rs_gf_pkg;

  localparam int unsigned SYM_W = 8;

  typedef logic [SYM_W-1:0] sym_t;
  typedef logic [SYM_W:0]   gf_poly_t;

  // Shift-and-add multiply; with one constant operand this folds to an XOR network.
  function automatic sym_t gf_mul(input sym_t a, input sym_t b, input gf_poly_t poly);
    gf_poly_t sh;
    sym_t     prod;
    sh   = {1'b0, a};
    prod = '0;
    for (int unsigned i = 0; i < SYM_W; i++) begin
      if (b[i]) prod = prod ^ sh[SYM_W-1:0];
      sh = sh << 1;
      if (sh[SYM_W]) sh = sh ^ poly;
    end
    return prod;
  endfunction

  // The multiplicative group has order 255, so the exponent is reduced first.
  function automatic sym_t gf_pow_const(input int unsigned e, input gf_poly_t poly);
    sym_t        r;
    int unsigned em;
    em = e % 255;
    r  = 8'h01;
    for (int unsigned i = 0; i < 255; i++) begin
      if (i < em) r = gf_mul(r, 8'h02, poly);
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_syn_lane.sv
// One syndrome accumulator evaluating the received polynomial at alpha^ROOT_EXP.
// Each loaded beat folds PAR symbols into the running value by parallel Horner steps.
//   clk, rst_n   clock, asynchronous active-low reset
//   beat_i       PAR symbols, symbol k at [8k+:8], symbol 0 is the highest degree
//   load_i       beat accepted this cycle
//   first_i      beat starts a new codeword (previous accumulation is dropped)
//   syn_next_o   value the accumulator takes if this beat loads (final syndrome on last beat)
module rs_syn_lane
  import rs_gf_pkg::*;
#(
  parameter int unsigned PAR      = 16,
  parameter int unsigned ROOT_EXP = 0,
  parameter logic [8:0]  GF_POLY  = 9'h11D
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PAR*SYM_W-1:0]   beat_i,
  input  logic                   load_i,
  input  logic                   first_i,
  output logic [SYM_W-1:0]       syn_next_o
);

  // Running value advances by r^PAR per beat.
  localparam sym_t STEP = gf_pow_const(ROOT_EXP * PAR, GF_POLY);

  sym_t syn_q, syn_d;
  sym_t term [PAR];

  for (genvar k = 0; k < PAR; k++) begin : g_term
    localparam sym_t COEF = gf_pow_const(ROOT_EXP * (PAR - 1 - k), GF_POLY);
    assign term[k] = gf_mul(beat_i[SYM_W*k +: SYM_W], COEF, GF_POLY);
  end

  always_comb begin
    syn_d = first_i ? '0 : gf_mul(syn_q, STEP, GF_POLY);
    for (int unsigned k = 0; k < PAR; k++) begin
      syn_d = syn_d ^ term[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syn_q <= '0;
    end else if (load_i) begin
      syn_q <= syn_d;
    end
  end

  assign syn_next_o = syn_d;

endmodule

// File: rtl/rs_syndrome_stream.sv
// Streaming Reed-Solomon syndrome calculator over GF(2^8). A codeword arrives as
// ceil(N_CW/PAR) beats of PAR symbols; NSYM syndromes are accumulated and handed
// to the key-equation solver through a valid/ready output register.
//   clk, rst_n          clock, asynchronous active-low reset
//   in_data             PAR symbols, symbol k (k=0 first, highest degree) at [8k+:8]
//   in_valid, in_ready  beat handshake
//   in_sop              first beat of a codeword
//   out_syn             syndrome j at [8j+:8]
//   out_nz              any syndrome non-zero
//   out_valid,out_ready result handshake
//   sop_err             one-cycle pulse after a beat that breaks framing
module rs_syndrome_stream
  import rs_gf_pkg::*;
#(
  parameter int unsigned PAR     = 16,
  parameter int unsigned NSYM    = 16,
  parameter int unsigned N_CW    = 255,
  parameter int unsigned FCR     = 0,
  parameter logic [8:0]  GF_POLY = 9'h11D
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PAR*8-1:0]      in_data,
  input  logic                  in_valid,
  input  logic                  in_sop,
  output logic                  in_ready,
  output logic [NSYM*8-1:0]     out_syn,
  output logic                  out_nz,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sop_err
);

  localparam int unsigned BEATS = (N_CW + PAR - 1) / PAR;
  localparam int unsigned PAD   = BEATS * PAR - N_CW;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic                  last_beat, accept, discard, restart, load, final_beat;
  logic [PAR*SYM_W-1:0]  beat_data;
  logic [NSYM*SYM_W-1:0] syn_next;
  logic [NSYM*SYM_W-1:0] out_syn_q;
  logic                  out_nz_q, out_valid_q, sop_err_q;

  assign last_beat = (beat_cnt_q == LAST);
  // Only the final beat needs the output register free; earlier beats flow on.
  assign in_ready  = !(last_beat && out_valid_q && !out_ready);
  assign accept    = in_valid && in_ready;
  assign discard   = accept && !in_sop && (beat_cnt_q == '0);
  assign restart   = accept && in_sop && (beat_cnt_q != '0);
  assign load      = accept && !discard;
  // An sop beat is always beat 0, so it is final only for single-beat codewords.
  assign final_beat = load && (in_sop ? (BEATS == 1) : last_beat);

  // Leading pad lanes of the first beat carry no codeword symbols.
  always_comb begin
    beat_data = in_data;
    if (in_sop) begin
      for (int unsigned k = 0; k < PAD; k++) begin
        beat_data[SYM_W*k +: SYM_W] = '0;
      end
    end
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (load) begin
      if (final_beat) begin
        beat_cnt_d = '0;
      end else if (in_sop) begin
        beat_cnt_d = CNT_W'(1);
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
  end

  for (genvar j = 0; j < NSYM; j++) begin : g_lane
    rs_syn_lane #(
      .PAR      (PAR),
      .ROOT_EXP (FCR + j),
      .GF_POLY  (GF_POLY)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .beat_i     (beat_data),
      .load_i     (load),
      .first_i    (in_sop),
      .syn_next_o (syn_next[SYM_W*j +: SYM_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q  <= '0;
      out_syn_q   <= '0;
      out_nz_q    <= 1'b0;
      out_valid_q <= 1'b0;
      sop_err_q   <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      sop_err_q  <= restart || discard;
      // A new result wins over the handshake of the old one.
      if (final_beat) begin
        out_syn_q   <= syn_next;
        out_nz_q    <= |syn_next;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_syn   = out_syn_q;
  assign out_nz    = out_nz_q;
  assign out_valid = out_valid_q;
  assign sop_err   = sop_err_q;

endmodule

// File: tb/tb_rs_syndrome_stream.sv
// Directed bench for rs_syndrome_stream at default parameters (PAR=16, 16 beats, 1 pad lane).
// Codeword position p (0..255, p=0 is the pad lane) has polynomial degree 255-p.
module tb_rs_syndrome_stream;

  localparam int unsigned PAR  = 16;
  localparam int unsigned NSYM = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [PAR*8-1:0]    in_data;
  logic                in_valid;
  logic                in_sop;
  logic                in_ready;
  logic [NSYM*8-1:0]   out_syn;
  logic                out_nz;
  logic                out_valid;
  logic                out_ready;
  logic                sop_err;

  int checks = 0;
  int errors = 0;
  logic [7:0] cw [256];

  rs_syndrome_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_sop    (in_sop),
    .in_ready  (in_ready),
    .out_syn   (out_syn),
    .out_nz    (out_nz),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sop_err   (sop_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_cw();
    for (int i = 0; i < 256; i++) cw[i] = 8'h00;
  endtask

  function automatic logic [PAR*8-1:0] beat_of(input int b);
    logic [PAR*8-1:0] v;
    for (int k = 0; k < PAR; k++) v[8*k +: 8] = cw[PAR*b + k];
    return v;
  endfunction

  // Drives one beat at posedge+1 and returns at posedge+1 after it is accepted.
  task automatic send_beat(input logic sop, input logic [PAR*8-1:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_sop   = sop;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
  endtask

  task automatic send_range(input int b0, input int b1);
    for (int b = b0; b <= b1; b++) send_beat(b == 0, beat_of(b));
  endtask

  initial begin
    in_valid  = 1'b0;
    in_sop    = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_nz", 128'(out_nz), 128'd0);
    check("rst_out_syn", out_syn, 128'd0);
    check("rst_sop_err", 128'(sop_err), 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All-zero codeword; result appears exactly one cycle after beat 15.
    clear_cw();
    send_range(0, 14);
    check("zero_valid_early", 128'(out_valid), 128'd0);
    send_range(15, 15);
    check("zero_valid", 128'(out_valid), 128'd1);
    check("zero_syn", out_syn, 128'd0);
    check("zero_nz", 128'(out_nz), 128'd0);
    @(posedge clk);
    #1;
    check("zero_valid_clear", 128'(out_valid), 128'd0);

    // Error 0x01 at degree 0: every syndrome is 0x01.
    clear_cw();
    cw[255] = 8'h01;
    send_range(0, 15);
    check("deg0_syn", out_syn, {16{8'h01}});
    check("deg0_nz", 128'(out_nz), 128'd1);

    // Error 0x01 at degree 1: S_j = alpha^j.
    clear_cw();
    cw[254] = 8'h01;
    send_range(0, 15);
    check("deg1_s0", 128'(out_syn[7:0]), 128'h01);
    check("deg1_s1", 128'(out_syn[15:8]), 128'h02);
    check("deg1_s2", 128'(out_syn[23:16]), 128'h04);
    check("deg1_s7", 128'(out_syn[63:56]), 128'h80);
    check("deg1_s8", 128'(out_syn[71:64]), 128'h1D);

    // Error 0x01 at degree 254 (first real symbol): S_j = alpha^(-j).
    clear_cw();
    cw[1] = 8'h01;
    send_range(0, 15);
    check("deg254_s0", 128'(out_syn[7:0]), 128'h01);
    check("deg254_s1", 128'(out_syn[15:8]), 128'h8E);
    check("deg254_s2", 128'(out_syn[23:16]), 128'h47);
    check("deg254_nz", 128'(out_nz), 128'd1);

    // Garbage on the pad lane must not reach the syndromes.
    clear_cw();
    cw[0] = 8'hFF;
    send_range(0, 15);
    check("pad_valid", 128'(out_valid), 128'd1);
    check("pad_syn", out_syn, 128'd0);
    check("pad_nz", 128'(out_nz), 128'd0);
    @(posedge clk);
    #1;

    // Back-pressure: first result held, second frame stalls only at its final beat.
    out_ready = 1'b0;
    clear_cw();
    cw[255] = 8'h01;
    send_range(0, 15);
    check("bp_a_valid", 128'(out_valid), 128'd1);
    clear_cw();
    cw[254] = 8'h01;
    send_range(0, 14);
    check("bp_a_hold_syn", out_syn, {16{8'h01}});
    check("bp_a_hold_valid", 128'(out_valid), 128'd1);
    in_valid = 1'b1;
    in_sop   = 1'b0;
    in_data  = beat_of(15);
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready_low", 128'(in_ready), 128'd0);
    end
    check("bp_a_hold_syn2", out_syn, {16{8'h01}});
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_high", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_b_valid", 128'(out_valid), 128'd1);
    check("bp_b_s1", 128'(out_syn[15:8]), 128'h02);
    check("bp_b_s8", 128'(out_syn[71:64]), 128'h1D);
    @(posedge clk);
    #1;
    check("bp_b_clear", 128'(out_valid), 128'd0);

    // sop at beat_cnt=5 aborts the frame and restarts it.
    for (int i = 0; i < 256; i++) cw[i] = 8'(i) ^ 8'h5A;
    send_range(0, 4);
    clear_cw();
    cw[255] = 8'h01;
    send_range(0, 0);
    check("restart_sop_err", 128'(sop_err), 128'd1);
    send_range(1, 14);
    check("restart_sop_err_clear", 128'(sop_err), 128'd0);
    check("restart_no_output", 128'(out_valid), 128'd0);
    send_range(15, 15);
    check("restart_valid", 128'(out_valid), 128'd1);
    check("restart_syn", out_syn, {16{8'h01}});
    @(posedge clk);
    #1;

    // Beat without sop at beat_cnt=0 is dropped.
    send_beat(1'b0, {16{8'hA5}});
    check("discard_sop_err", 128'(sop_err), 128'd1);
    check("discard_no_output", 128'(out_valid), 128'd0);
    clear_cw();
    cw[254] = 8'h01;
    send_range(0, 0);
    check("discard_cnt_zero", 128'(sop_err), 128'd0);
    send_range(1, 15);
    check("discard_s0", 128'(out_syn[7:0]), 128'h01);
    check("discard_s1", 128'(out_syn[15:8]), 128'h02);

    // Reset mid-frame with a result held.
    out_ready = 1'b0;
    send_range(0, 6);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 128'(out_valid), 128'd0);
    check("midrst_syn", out_syn, 128'd0);
    check("midrst_nz", 128'(out_nz), 128'd0);
    check("midrst_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    clear_cw();
    cw[255] = 8'h05;
    send_range(0, 0);
    check("midrst_cnt_zero", 128'(sop_err), 128'd0);
    send_range(1, 15);
    check("midrst_syn_after", out_syn, {16{8'h05}});
    check("midrst_valid_after", 128'(out_valid), 128'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
